// File: rtl/pipe_regfile_pkg.sv
// Shared defaults and the address-width helper for the pipelined register file.
package pipe_regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 8;
  localparam int DEF_NRD    = 2;
  localparam int DEF_PC_IDX = 7;

  // A single-entry file still needs a one-bit address.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One read port: address decode, optional same-cycle write bypass, reset forcing.
// Bypass is compiled in only when PIPE_REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int PC_IDX = DEF_PC_IDX,
  parameter int AW     = calc_aw(DEF_NREGS)
) (
  input  logic                    reset,
  input  logic [AW-1:0]           rd_addr,
  input  logic [NREGS*DATA_W-1:0] regs_flat,
  input  logic [NREGS-1:0]        busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pc_wr_en,
  input  logic [DATA_W-1:0]       pc_wr_data,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_busy
);

  logic [DATA_W-1:0] data_sel;
  logic              busy_sel;
  logic              hit;

`ifndef PIPE_REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_en, wr_addr, wr_data, pc_wr_en, pc_wr_data};
`endif

  always_comb begin
    data_sel = '0;
    busy_sel = 1'b0;
    hit      = 1'b0;
    // Addresses past NREGS never match, so they read as zero and idle.
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr == AW'(i)) begin
        data_sel = regs_flat[i*DATA_W +: DATA_W];
        busy_sel = busy[i];
        hit      = 1'b1;
      end
    end
`ifdef PIPE_REGFILE_BYPASS_EN
    if (hit && wr_en && (rd_addr == wr_addr)) begin
      data_sel = wr_data;
      busy_sel = 1'b0;
    end else if (hit && pc_wr_en && (rd_addr == AW'(PC_IDX))) begin
      data_sel = pc_wr_data;
    end
`endif
    if (reset) begin
      data_sel = '0;
      busy_sel = 1'b0;
    end
  end

  assign rd_data = data_sel;
  assign rd_busy = busy_sel;

endmodule

// File: rtl/pipe_regfile.sv
// Register file with dedicated PC write port, issue scoreboard and NRD read ports.
// Optional same-cycle read bypass is enabled by defining PIPE_REGFILE_BYPASS_EN.
module pipe_regfile
  import pipe_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = DEF_NRD,
  parameter int PC_IDX = DEF_PC_IDX,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*AW-1:0]       rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    pc_wr_en,
  input  logic [DATA_W-1:0]       pc_wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    flush,
  output logic [NREGS*DATA_W-1:0] regs_flat,
  output logic [NREGS-1:0]        busy
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [NREGS-1:0]  busy_q;
  logic [NREGS-1:0]  busy_d;

  // Later assignments take priority: general write over PC write, issue over
  // writeback clear, flush over everything.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (pc_wr_en && (i == PC_IDX)) regs_d[i] = pc_wr_data;
      if (wr_en && (wr_addr == AW'(i))) begin
        regs_d[i] = wr_data;
        busy_d[i] = 1'b0;
      end
      if (iss_en && (iss_addr == AW'(i))) busy_d[i] = 1'b1;
      if (flush) busy_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_flat
      assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      regfile_read_port #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .PC_IDX (PC_IDX),
        .AW     (AW)
      ) u_rd (
        .reset      (reset),
        .rd_addr    (rd_addr[gi*AW +: AW]),
        .regs_flat  (regs_flat),
        .busy       (busy_q),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pc_wr_en   (pc_wr_en),
        .pc_wr_data (pc_wr_data),
        .rd_data    (rd_data[gi*DATA_W +: DATA_W]),
        .rd_busy    (rd_busy[gi])
      );
    end
  endgenerate

  assign busy = busy_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench for pipe_regfile with an array-based reference model checked every cycle.
module tb_pipe_regfile;

  logic        clk;
  logic        reset;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        pc_wr_en;
  logic [15:0] pc_wr_data;
  logic        iss_en;
  logic [2:0]  iss_addr;
  logic        flush;
  logic [127:0] regs_flat;
  logic [7:0]  busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  logic [15:0] m_regs [8];
  logic [7:0]  m_busy;

  pipe_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pc_wr_en   (pc_wr_en),
    .pc_wr_data (pc_wr_data),
    .iss_en     (iss_en),
    .iss_addr   (iss_addr),
    .flush      (flush),
    .regs_flat  (regs_flat),
    .busy       (busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: apply the write/issue/flush rules in priority order.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      if (pc_wr_en && !(wr_en && wr_addr == 3'd7)) m_regs[7] <= pc_wr_data;
      if (wr_en) begin
        m_regs[wr_addr] <= wr_data;
        m_busy[wr_addr] <= 1'b0;
      end
      if (iss_en) m_busy[iss_addr] <= 1'b1;
      if (flush) m_busy <= '0;
    end
  end

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (reset) return 16'h0;
`ifdef PIPE_REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
    if (pc_wr_en && a == 3'd7) return pc_wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (reset) return 1'b0;
`ifdef PIPE_REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [127:0] flat;
      for (int i = 0; i < 8; i++) flat[i*16 +: 16] = m_regs[i];
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rd_data%0d", k), 128'(rd_data[k*16 +: 16]), 128'(exp_data(rd_addr[k*3 +: 3])));
        chk($sformatf("rd_busy%0d", k), 128'(rd_busy[k]), 128'(exp_busy(rd_addr[k*3 +: 3])));
      end
      chk("regs_flat", regs_flat, flat);
      chk("busy", 128'(busy), 128'(m_busy));
    end
  end

  task automatic step(input string note);
    $display("txn %0t: %s", $time, note);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 0; pc_wr_en = 0; iss_en = 0; flush = 0;
  endtask

  initial begin
    reset = 1; rd_addr = '0; idle();
    wr_addr = '0; wr_data = '0; pc_wr_data = '0; iss_addr = '0;
    step("reset");
    chk_en = 1;
    step("reset hold");
    reset = 0;

    // Everything reads zero and idle after reset.
    for (int i = 0; i < 8; i++) begin
      rd_addr = {3'(i), 3'(7 - i)};
      step($sformatf("read addr %0d/%0d", i, 7 - i));
      chk("post-reset rd_data", 128'(rd_data), 128'(0));
      chk("post-reset rd_busy", 128'(rd_busy), 128'(0));
    end

    // Write then read: visible next cycle (or same cycle with bypass).
    wr_en = 1; wr_addr = 3; wr_data = 16'hABCD; rd_addr = {3'd3, 3'd3};
    #1;
`ifdef PIPE_REGFILE_BYPASS_EN
    chk("same-cycle read r3", 128'(rd_data[15:0]), 128'(16'hABCD));
`else
    chk("same-cycle read r3", 128'(rd_data[15:0]), 128'(16'h0000));
`endif
    step("write r3=ABCD");
    idle();
    #1;
    chk("next-cycle read r3 p0", 128'(rd_data[15:0]), 128'(16'hABCD));
    chk("next-cycle read r3 p1", 128'(rd_data[31:16]), 128'(16'hABCD));

    // PC write alone, then general write colliding on the PC register.
    pc_wr_en = 1; pc_wr_data = 16'h3333;
    step("pc write 3333");
    chk("pc alone", 128'(regs_flat[127:112]), 128'(16'h3333));
    wr_en = 1; wr_addr = 7; wr_data = 16'h1111; pc_wr_data = 16'h2222;
    step("wr r7=1111 + pc 2222");
    idle();
    chk("r7 general wins", 128'(regs_flat[127:112]), 128'(16'h1111));
    wr_en = 1; wr_addr = 1; wr_data = 16'h0101; pc_wr_en = 1; pc_wr_data = 16'h7777;
    step("wr r1 + pc 7777");
    idle();
    chk("r1 parallel", 128'(regs_flat[31:16]), 128'(16'h0101));
    chk("r7 parallel", 128'(regs_flat[127:112]), 128'(16'h7777));

    // Scoreboard: issue beats writeback clear in the same cycle.
    rd_addr = {3'd7, 3'd2};
    iss_en = 1; iss_addr = 2;
    step("issue r2");
    idle();
    chk("busy2 after issue", 128'(busy[2]), 128'(1));
    wr_en = 1; wr_addr = 2; wr_data = 16'h0202; iss_en = 1; iss_addr = 2;
    step("wr r2 + issue r2");
    idle();
    chk("busy2 issue wins", 128'(busy[2]), 128'(1));
    pc_wr_en = 1; pc_wr_data = 16'h8888;
    step("pc write keeps busy");
    idle();
    chk("busy2 after pc", 128'(rd_busy[0]), 128'(1));
    wr_en = 1; wr_addr = 2; wr_data = 16'h0222;
    step("wr r2 alone");
    idle();
    chk("busy2 cleared", 128'(busy[2]), 128'(0));

    // Flush overrides a same-cycle issue but not a register write.
    foreach (busy[i]) begin end
    iss_en = 1; iss_addr = 1; step("issue r1");
    iss_addr = 4; step("issue r4");
    iss_addr = 5; step("issue r5");
    idle();
    chk("busy 1/4/5", 128'(busy), 128'(8'b0011_0010));
    flush = 1; iss_en = 1; iss_addr = 6; wr_en = 1; wr_addr = 0; wr_data = 16'h5A5A;
    step("flush + issue r6 + wr r0");
    idle();
    chk("busy after flush", 128'(busy), 128'(0));
    chk("r0 during flush", 128'(regs_flat[15:0]), 128'(16'h5A5A));

    // Duplicate/varied read addresses over a sweep of writes.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_addr = 3'(i); wr_data = 16'(16'h1000 * i + 16'h0011 * (7 - i));
      rd_addr = {3'(i), 3'(i)};
      iss_en = (i % 3 == 0); iss_addr = 3'(7 - i);
      step($sformatf("sweep wr r%0d", i));
    end
    idle();
    step("sweep idle");

    // Reset drops a same-cycle write and forces reads to zero.
    wr_en = 1; wr_addr = 5; wr_data = 16'h00FF; rd_addr = {3'd5, 3'd5};
    step("wr r5=00FF");
    idle();
    chk("r5 before reset", 128'(regs_flat[95:80]), 128'(16'h00FF));
    reset = 1; wr_en = 1; wr_addr = 5; wr_data = 16'hFFFF; iss_en = 1; iss_addr = 3;
    #1;
    chk("rd_data in reset", 128'(rd_data), 128'(0));
    step("reset + wr r5=FFFF");
    chk("r5 after reset", 128'(regs_flat[95:80]), 128'(16'h0000));
    chk("rd_data still reset", 128'(rd_data), 128'(0));
    idle(); reset = 0;
    step("release reset");
    chk("busy after reset", 128'(busy), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
